ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 116 +++++++++++
 tb/tb_ram_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Four-requester arbiter sharing a single synchronous RAM port.
// Round-robin grants, with an optional per-requester lock that an idle timeout can break.
module ram_port_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              req_valid,
  output logic [3:0]              req_ready,
  input  logic [3:0]              req_we,
  input  logic [3:0]              req_lock,
  input  logic [4*ADDR_WIDTH-1:0] req_addr,
  input  logic [4*DATA_WIDTH-1:0] req_wdata,
  output logic [3:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    lock_timeout,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(LOCK_TIMEOUT - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] owner;
  logic [7:0] idle_cnt;

  logic       grant_any;
  logic [1:0] grant_idx;
  logic [1:0] scan_idx;

  // Descending scan so the requester closest to ptr is assigned last and wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    scan_idx  = 2'd0;
    if (state == LOCKED) begin
      grant_any = req_valid[owner];
      grant_idx = owner;
    end else begin
      for (int k = 3; k >= 0; k--) begin
        scan_idx = ptr + 2'(k);
        if (req_valid[scan_idx]) begin
          grant_any = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready = 4'b0000;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
      ram_we   = req_we[grant_idx];
      ram_addr = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      ram_din  = req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rsp_rdata = ram_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= UNLOCKED;
      ptr          <= 2'd0;
      owner        <= 2'd0;
      idle_cnt     <= 8'd0;
      rsp_valid    <= 4'b0000;
      lock_timeout <= 1'b0;
    end else begin
      rsp_valid    <= (grant_any && !req_we[grant_idx]) ? req_ready : 4'b0000;
      lock_timeout <= 1'b0;
      case (state)
        UNLOCKED: begin
          idle_cnt <= 8'd0;
          if (grant_any) begin
            ptr <= grant_idx + 2'd1;
            if (req_lock[grant_idx]) begin
              state <= LOCKED;
              owner <= grant_idx;
            end
          end
        end
        LOCKED: begin
          if (grant_any) begin
            idle_cnt <= 8'd0;
            if (!req_lock[owner]) begin
              state <= UNLOCKED;
              ptr   <= owner + 2'd1;
            end
          end else if (idle_cnt == TIMEOUT_LAST) begin
            // This idle cycle brings the count to LOCK_TIMEOUT: release the lock.
            state        <= UNLOCKED;
            ptr          <= owner + 2'd1;
            idle_cnt     <= 8'd0;
            lock_timeout <= 1'b1;
          end else if (idle_cnt != 8'hFF) begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a reference model predicts grants, RAM port
// drive, read responses and lock-timeout pulses; a monitor checks the registered outputs.
module tb_ram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 15;

  logic            clk;
  logic            rst_n;
  logic [3:0]      req_valid, req_ready, req_we, req_lock;
  logic [4*AW-1:0] req_addr;
  logic [4*DW-1:0] req_wdata;
  logic [3:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            lock_timeout;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_din;
  logic [DW-1:0]   ram_dout;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .lock_timeout(lock_timeout),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The RAM the arbiter drives: one-cycle read latency, contents survive reset.
  logic [DW-1:0] ram_mem [1<<AW];
  initial for (int i = 0; i < (1 << AW); i++) ram_mem[i] = '0;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int            due;
    logic [3:0]    mask;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t rsp_q[$];
  int   to_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] model_mem [1<<AW];
  initial for (int i = 0; i < (1 << AW); i++) model_mem[i] = '0;
  bit   m_locked;
  int   m_ptr, m_owner, m_idle;
  logic [3:0] last_ready;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void modelReset();
    m_locked = 0;
    m_ptr    = 0;
    m_owner  = 0;
    m_idle   = 0;
    rsp_q.delete();
    to_q.delete();
  endfunction

  function automatic int modelWinner(input logic [3:0] v);
    if (m_locked) return v[m_owner] ? m_owner : -1;
    for (int off = 0; off < 4; off++)
      if (v[(m_ptr + off) % 4]) return (m_ptr + off) % 4;
    return -1;
  endfunction

  // Drive one cycle of requests (called at a falling edge), check the combinational
  // grant and RAM drive, queue expected responses, then advance the model one clock.
  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] w, input logic [3:0] l,
                               input logic [4*AW-1:0] a, input logic [4*DW-1:0] d,
                               input bit reset_after = 0);
    int         win;
    logic [3:0] exp_ready;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    req_valid = v; req_we = w; req_lock = l; req_addr = a; req_wdata = d;
    #1;
    win       = modelWinner(v);
    exp_ready = (win >= 0) ? (4'b0001 << win) : 4'b0000;
    wa        = (win >= 0) ? a[win*AW +: AW] : '0;
    wd        = (win >= 0) ? d[win*DW +: DW] : '0;
    last_ready = req_ready;
    checkOutput("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
    checkOutput("ram_we", {31'd0, ram_we}, {31'd0, (win >= 0) && w[win]});
    checkOutput("ram_addr", {28'd0, ram_addr}, {28'd0, wa});
    checkOutput("ram_din", {24'd0, ram_din}, {24'd0, wd});
    if (win >= 0) begin
      if (w[win]) model_mem[wa] = wd;
      else rsp_q.push_back('{due: cyc + 1, mask: exp_ready, data: model_mem[wa]});
    end
    if (!m_locked) begin
      if (win >= 0) begin
        m_ptr = (win + 1) % 4;
        if (l[win]) begin m_locked = 1; m_owner = win; m_idle = 0; end
      end
    end else if (win >= 0) begin
      m_idle = 0;
      if (!l[m_owner]) begin m_locked = 0; m_ptr = (m_owner + 1) % 4; end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        m_locked = 0; m_ptr = (m_owner + 1) % 4; m_idle = 0;
        to_q.push_back(cyc + 1);
      end
    end
    @(posedge clk);
    if (reset_after) begin
      #1;
      rst_n = 1'b0;
      modelReset();
    end
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: registered outputs are compared with whatever the scoreboard expects this cycle.
  initial begin
    rsp_t e;
    logic [3:0]    exp_mask;
    logic          exp_to;
    forever begin
      @(negedge clk);
      while (rsp_q.size() > 0 && rsp_q[0].due < cyc) begin
        e = rsp_q.pop_front();
        checkOutput("rsp_stale", 32'd1, 32'd0);
      end
      exp_mask = 4'b0000;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        e = rsp_q.pop_front();
        exp_mask = e.mask;
        checkOutput("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.data});
      end
      checkOutput("rsp_valid", {28'd0, rsp_valid}, {28'd0, exp_mask});
      exp_to = 1'b0;
      if (to_q.size() > 0 && to_q[0] == cyc) begin
        void'(to_q.pop_front());
        exp_to = 1'b1;
      end
      checkOutput("lock_timeout", {31'd0, lock_timeout}, {31'd0, exp_to});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_ready", {28'd0, req_ready}, 32'd0);
    checkOutput("reset_rsp", {28'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read back the same address from requester 0.
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 16'h0004, 32'h0000_00AA);
    checkOutput("wr_grant", {28'd0, last_ready}, 32'h1);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 16'h0004, 32'h0);
    checkOutput("rd_grant", {28'd0, last_ready}, 32'h1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 16'h0, 32'h0);

    // Round-robin rotation with every requester holding a read.
    applyReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 4'b0000, 4'b0000, 16'h3210, 32'h0);
      checkOutput("rr_seq", {28'd0, last_ready}, 32'(4'b0001 << (i % 4)));
    end

    // Requester 2 holds a lock while requester 0 waits.
    applyReset();
    applyStimulus(4'b0100, 4'b0100, 4'b0100, 16'h0600, 32'h00BB_0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0101, 4'b0100, 4'b0100, 16'h0600, 32'h00BB_0000);
      checkOutput("lock_hold", {28'd0, last_ready}, 32'h4);
    end
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 16'h0006, 32'h0);
    checkOutput("lock_block", {28'd0, last_ready}, 32'h0);
    applyStimulus(4'b0101, 4'b0100, 4'b0000, 16'h0600, 32'h00BB_0000);
    checkOutput("lock_release", {28'd0, last_ready}, 32'h4);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 16'h0006, 32'h0);
    checkOutput("after_unlock", {28'd0, last_ready}, 32'h1);

    // Requester 1 locks then goes idle; requester 3 gets in once the lock times out.
    applyReset();
    applyStimulus(4'b0010, 4'b0000, 4'b0010, 16'h0020, 32'h0);
    for (int i = 0; i < TO; i++) begin
      applyStimulus(4'b1000, 4'b0000, 4'b0000, 16'h5000, 32'h0);
      checkOutput("idle_block", {28'd0, last_ready}, 32'h0);
    end
    applyStimulus(4'b1000, 4'b0000, 4'b0000, 16'h5000, 32'h0);
    checkOutput("timeout_grant", {28'd0, last_ready}, 32'h8);

    // Reset right after a read accept drops the pending response.
    applyReset();
    applyStimulus(4'b1000, 4'b0000, 4'b0000, 16'h4000, 32'h0, 1'b1);
    checkOutput("rst_drop", {28'd0, rsp_valid}, 32'h0);
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 16'h0, 32'h0);
    checkOutput("post_rst_grant", {28'd0, last_ready}, 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] v, w, l;
      for (int b = 0; b < 4; b++) begin
        v[b] = ($urandom % 3) == 0;
        w[b] = $urandom % 2;
        l[b] = ($urandom % 4) == 0;
      end
      applyStimulus(v, w, l, 16'($urandom), $urandom);
    end

    applyStimulus(4'b0000, 4'b0000, 4'b0000, 16'h0, 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 16'h0, 32'h0);
    checkOutput("rsp_drained", 32'(rsp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
